key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 130 +++++++++++++
 rtl/key_debounce.sv | 34 +++
 tb/tb_key_debounce.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debouncer.
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } ch_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Width large enough that no terminal count can ever wrap the counter.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, saturating counter, 4-state FSM.
// Auto-repeat pulses on press_o are built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};
  localparam cnt_t DB_TERM = cnt_t'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam cnt_t DLY_TERM = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t PER_TERM = cnt_t'(REPEAT_PERIOD - 1);
`endif

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [1:0] sync_q;
  logic       pressed;
  ch_state_e  state_q;
  cnt_t       cnt_q;
  logic       level_q;
  logic       press_q;
  logic       release_q;
`ifdef KEY_AUTOREPEAT_EN
  logic       rep_q;
`endif

  // Inversion ahead of the synchronizer so the reset value 0 means released.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], ~key_n_i};
  end

  assign pressed = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q     <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pressed) state_q <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_TERM) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rep_q   <= 1'b0;
`endif
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
          else if (cnt_q == (rep_q ? PER_TERM : DLY_TERM)) begin
            press_q <= 1'b1;
            rep_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q   <= 1'b0;
`endif
          end else if (cnt_q == DB_TERM) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// N_KEYS independent debounce channels for active-low push-buttons.
// Define KEY_AUTOREPEAT_EN to add auto-repeat pulses on key_press.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (CLOCK_50),
      .rst_i    (RST),
      .key_n_i  (KEY[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] level, press, rel;

  int total = 0;
  int bad   = 0;

  key_debounce #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLOCK_50(clk), .RST(rst), .KEY(key),
    .key_level(level), .key_press(press), .key_release(rel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pedge, npress, redge, nrel, e0, cnt;
    int offs[$];
    int exp_offs[$];

    // Press KEY[0] at edge 1, level rises at edge 7; release, pulse at release edge 7.
    for (int i = 0; i < 16; i++) begin
      tbl[i].key = (i < 8) ? 4'b1110 : 4'b1111;
      tbl[i].lvl = (i >= 6 && i < 14) ? 4'b0001 : 4'b0000;
      tbl[i].prs = (i == 6) ? 4'b0001 : 4'b0000;
      tbl[i].rls = (i == 14) ? 4'b0001 : 4'b0000;
    end

    rst = 1'b1;
    key = 4'b1111;
    idle_wait(3);
    check("reset_level", {28'd0, level}, 32'd0);
    check("reset_press", {28'd0, press}, 32'd0);
    check("reset_release", {28'd0, rel}, 32'd0);
    rst = 1'b0;
    idle_wait(2);

    for (int i = 0; i < 16; i++) begin
      key = tbl[i].key;
      step();
      check($sformatf("tbl%0d_level", i), {28'd0, level}, {28'd0, tbl[i].lvl});
      check($sformatf("tbl%0d_press", i), {28'd0, press}, {28'd0, tbl[i].prs});
      check($sformatf("tbl%0d_release", i), {28'd0, rel}, {28'd0, tbl[i].rls});
    end
    idle_wait(3);

    // Bouncing KEY[1] never settles long enough to register.
    for (int i = 0; i < 40; i++) begin
      key[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      check($sformatf("bounce%0d", i), {29'd0, level[1], press[1], rel[1]}, 32'd0);
    end
    key[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bounce_hold%0d", i), {29'd0, level[1], press[1], rel[1]}, 32'd0);
    end

    // KEY[2] press then release: one press at edge 7, one release 7 edges later.
    key[2] = 1'b0;
    pedge = 0; npress = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (press[2]) begin npress++; if (pedge == 0) pedge = n; end
      if (level[2]) break;
    end
    check("k2_press_edge", pedge, 7);
    key[2] = 1'b1;
    redge = 0; nrel = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (press[2]) npress++;
      if (rel[2]) begin nrel++; if (redge == 0) redge = n; end
    end
    check("k2_release_edge", redge, 7);
    check("k2_release_count", nrel, 1);
    check("k2_press_count", npress, 1);

    // Reset while KEY[3] is PRESSED, then re-debounce after deassertion.
    key[3] = 1'b0;
    idle_wait(9);
    check("k3_level_before_rst", {31'd0, level[3]}, 32'd1);
    rst = 1'b1;
    #1;
    check("k3_rst_immediate", {20'd0, level, press, rel}, 32'd0);
    nrel = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("k3_in_rst%0d", i), {20'd0, level, press, rel}, 32'd0);
    end
    rst = 1'b0;
    pedge = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (rel[3]) nrel++;
      if (press[3] && pedge == 0) pedge = n;
      if (pedge != 0) break;
    end
    check("k3_repress_edge", pedge, 7);
    check("k3_no_release", nrel, 0);
    key[3] = 1'b1;
    idle_wait(12);

    // KEY[0] held: auto-repeat offsets from the initial press pulse.
    key[0] = 1'b0;
    e0 = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (press[0]) begin e0 = n; break; end
    end
    check("k0_hold_press_edge", e0, 7);
    cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (press[0]) offs.push_back(k);
      if (level[0]) cnt++;
    end
    check("k0_hold_level", cnt, 30);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 10; k <= 30; k += 3) exp_offs.push_back(k);
`endif
    check("k0_repeat_count", offs.size(), exp_offs.size());
    for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
      check($sformatf("k0_repeat%0d", i), offs[i], exp_offs[i]);
    key[0] = 1'b1;
    idle_wait(12);

    // All four keys pressed together.
    key = 4'b0000;
    for (int n = 1; n <= 8; n++) begin
      step();
      check($sformatf("all_press_e%0d", n), {28'd0, press}, (n == 7) ? 32'hF : 32'h0);
      if (n == 7) check("all_level_e7", {28'd0, level}, 32'hF);
    end
    key = 4'b1111;
    idle_wait(12);
    check("final_level", {28'd0, level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
